// File: rtl/serial_tx.sv
// Serial transmitter: captures a parallel word on tx_start and sends it as
// start bit (0), DATA_WIDTH data bits LSB first, stop bit (1).
module serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_line,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic                  bit_end;

  assign shift_next = shift_reg >> 1;
  assign bit_end    = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      tx_line   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tx_start) begin
            state_reg <= START;
            shift_reg <= tx_data;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            busy      <= 1'b1;
            tx_line   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_reg <= DATA;
            cnt_reg   <= '0;
            tx_line   <= shift_reg[0];
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_reg <= '0;
            if (idx_reg == IDX_LAST) begin
              state_reg <= STOP;
              tx_line   <= 1'b1;
            end else begin
              // present the next bit on the same edge that shifts it down
              idx_reg   <= idx_reg + 1'b1;
              shift_reg <= shift_next;
              tx_line   <= shift_next[0];
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: table-driven frames, random frames against a
// per-cycle arithmetic model, reset corners and a W=1/C=1 instance.
module tb_serial_tx;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int FL = C * (W + 2);

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         tx_start = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_line, busy, done;
  logic         tx_start1 = 1'b0;
  logic [0:0]   tx_data1 = '0;
  logic         tx_line1, busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx_line(tx_line), .busy(busy), .done(done)
  );

  serial_tx #(.DATA_WIDTH(1), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .tx_start(tx_start1), .tx_data(tx_data1),
    .tx_line(tx_line1), .busy(busy1), .done(done1)
  );

  // Expected {tx_line, busy, done} after the k-th edge following the accepting edge.
  function automatic logic [2:0] model(int w, int c, int k, logic [7:0] d);
    int   p = k / c;
    logic ln;
    if (p == 0)      ln = 1'b0;
    else if (p <= w) ln = d[p-1];
    else             ln = 1'b1;
    return {ln, (k < c * (w + 2)), (k == c * (w + 2))};
  endfunction

  task automatic check3(string name, logic [2:0] act, logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: line/busy/done got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle(int n, string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check3(name, {tx_line, busy, done}, 3'b100);
    end
  endtask

  // Called at a negedge. Sends d, checks every cycle up to the done cycle and
  // the mid-period line samples against exp_frame (bit 0 = start bit).
  task automatic frame8(logic [7:0] d, bit hold, int inject_k, logic [W+1:0] exp_frame,
                        string name);
    logic [W+1:0] got;
    got      = '0;
    tx_start = 1'b1;
    tx_data  = d;
    @(posedge clk);
    for (int k = 0; k <= FL; k++) begin
      @(negedge clk);
      check3($sformatf("%s k=%0d", name, k), {tx_line, busy, done}, model(W, C, k, d));
      if ((k % C) == (C / 2) && (k / C) <= W + 1) got[k/C] = tx_line;
      tx_start = hold || (k == inject_k);
      tx_data  = (k == inject_k) ? 8'h3C : W'($urandom);
    end
    checks++;
    if (got !== exp_frame) begin
      errors++;
      $display("FAIL %s frame bits: got %b expected %b", name, got, exp_frame);
    end
    $display("frame %s data=%h errors=%0d", name, d, errors);
  endtask

  typedef struct {
    logic [7:0]   data;
    bit           hold;
    int           inject_k;
    logic [W+1:0] exp_frame;
    string        name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, -1,     10'b1_10100101_0, "A5"};
    vecs[1] = '{8'h81, 1'b0, 13,     10'b1_10000001_0, "81_ign_mid"};
    vecs[2] = '{8'h81, 1'b0, FL - 1, 10'b1_10000001_0, "81_ign_laststop"};
    vecs[3] = '{8'h00, 1'b1, -1,     10'b1_00000000_0, "00_hold"};
    vecs[4] = '{8'hFF, 1'b0, -1,     10'b1_11111111_0, "FF_b2b"};
    vecs[5] = '{8'h3C, 1'b0, 5,      10'b1_00111100_0, "3C"};
    vecs[6] = '{8'h01, 1'b0, -1,     10'b1_00000001_0, "01"};
    vecs[7] = '{8'h80, 1'b0, 30,     10'b1_10000000_0, "80"};

    // asynchronous reset before any clock edge
    #2 reset = 1'b1;
    #1;
    check3("reset_async", {tx_line, busy, done}, 3'b100);
    check3("reset_async_w1", {tx_line1, busy1, done1}, 3'b100);
    @(negedge clk);
    reset = 1'b0;
    idle(20, "idle_after_reset");

    foreach (vecs[i]) begin
      frame8(vecs[i].data, vecs[i].hold, vecs[i].inject_k, vecs[i].exp_frame, vecs[i].name);
      if (!vecs[i].hold) idle(1, {vecs[i].name, "_idle"});
    end

    // reset during data bit 3 of 8'h55: abort, no done pulse
    tx_start = 1'b1;
    tx_data  = 8'h55;
    @(posedge clk);
    for (int k = 0; k <= 4 * C + 1; k++) begin
      @(negedge clk);
      check3($sformatf("55 k=%0d", k), {tx_line, busy, done}, model(W, C, k, 8'h55));
      tx_start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    check3("reset_midframe", {tx_line, busy, done}, 3'b100);
    @(negedge clk);
    reset = 1'b0;
    idle(FL, "after_abort");
    frame8(8'h0F, 1'b0, -1, 10'b1_00001111_0, "0F_after_reset");
    idle(1, "0F_idle");

    // random frames, random stray starts, random back-to-back
    for (int n = 0; n < 25; n++) begin
      logic [7:0] d;
      bit         hold;
      int         inj;
      d    = 8'($urandom);
      hold = (n != 24) && ($urandom_range(0, 3) == 0);
      inj  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FL - 1)) : -1;
      frame8(d, hold, inj, {1'b1, d, 1'b0}, $sformatf("rnd%0d", n));
      if (!hold) idle(int'($urandom_range(1, 3)), "rnd_idle");
    end

    // W=1, C=1 corner: line 0, d, 1 then done after edge E0+3
    for (int r = 0; r < 2; r++) begin
      tx_start1 = 1'b1;
      tx_data1  = (r == 0) ? 1'b1 : 1'b0;
      @(posedge clk);
      for (int k = 0; k <= 3; k++) begin
        @(negedge clk);
        check3($sformatf("w1c1 d=%0d k=%0d", tx_data1, k), {tx_line1, busy1, done1},
               model(1, 1, k, {7'b0, tx_data1}));
        tx_start1 = 1'b0;
      end
      @(negedge clk);
      check3("w1c1_idle", {tx_line1, busy1, done1}, 3'b100);
      $display("frame w1c1 data=%0d errors=%0d", tx_data1, errors);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
